// File: rtl/vending_controller.sv
// Vending-machine money sequencer: coin insertion, drink dispense and change return.
// Owns the credit register and drives the display value and affordable-drink LEDs.
module vending_controller #(
   parameter int unsigned MONEY_BIT   = 8,
   parameter int unsigned MONEY_MAX   = 99,
   parameter int unsigned PRICE_A     = 20,
   parameter int unsigned PRICE_S     = 25,
   parameter int unsigned PRICE_D     = 30,
   parameter int unsigned PRICE_F     = 60,
   parameter int unsigned CHANGE_STEP = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_general,
   input  logic                 tick_second,
   input  logic                 coin_5,
   input  logic                 coin_10,
   input  logic                 coin_50,
   input  logic                 cancel,
   input  logic [3:0]           buy_req,
   output logic [MONEY_BIT-1:0] money,
   output logic [1:0]           state,
   output logic [3:0]           affordable,
   output logic [3:0]           dispense,
   output logic [3:0]           drink_sel,
   output logic                 change_out
);

   localparam logic [1:0] ST_INSERT = 2'b00;
   localparam logic [1:0] ST_BUY    = 2'b01;
   localparam logic [1:0] ST_RETURN = 2'b10;

   localparam int unsigned          SUM_W = MONEY_BIT + 1;
   localparam logic [SUM_W-1:0]     MAX_W = SUM_W'(MONEY_MAX);
   localparam logic [MONEY_BIT-1:0] STEP  = MONEY_BIT'(CHANGE_STEP);

   logic [1:0]           state_q, state_d;
   logic [MONEY_BIT-1:0] money_q, money_d;
   logic [3:0]           dispense_q, dispense_d;
   logic [3:0]           drink_sel_q, drink_sel_d;
   logic                 change_q, change_d;

   logic [MONEY_BIT-1:0] price [4];
   logic [1:0]           buy_idx;
   logic [3:0]           buy_hot;
   logic [SUM_W-1:0]     coin_val;
   logic [SUM_W-1:0]     coin_sum;
   logic [MONEY_BIT-1:0] coin_sat;
   logic [MONEY_BIT-1:0] ret_dec;
   logic [MONEY_BIT-1:0] money_ret;

   assign price[0] = MONEY_BIT'(PRICE_A);
   assign price[1] = MONEY_BIT'(PRICE_S);
   assign price[2] = MONEY_BIT'(PRICE_D);
   assign price[3] = MONEY_BIT'(PRICE_F);

   // Lowest set request bit wins.
   always_comb begin
      buy_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (buy_req[i]) buy_idx = 2'(i);
      end
      buy_hot = 4'b0001 << buy_idx;
   end

   always_comb begin
      if (coin_5)       coin_val = SUM_W'(5);
      else if (coin_10) coin_val = SUM_W'(10);
      else              coin_val = SUM_W'(50);
      // One extra bit so the sum cannot wrap before saturation.
      coin_sum = {1'b0, money_q} + coin_val;
      coin_sat = (coin_sum > MAX_W) ? MAX_W[MONEY_BIT-1:0] : coin_sum[MONEY_BIT-1:0];
      ret_dec   = (money_q < STEP) ? money_q : STEP;
      money_ret = money_q - ret_dec;
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         affordable[i] = (state_q == ST_INSERT) && (money_q >= price[i]);
      end
   end

   always_comb begin
      state_d     = state_q;
      money_d     = money_q;
      dispense_d  = 4'b0000;
      drink_sel_d = drink_sel_q;
      change_d    = 1'b0;
      case (state_q)
         ST_INSERT: begin
            if (tick_general) begin
               if (cancel) begin
                  if (money_q != '0) state_d = ST_RETURN;
               end else if (buy_req != 4'b0000) begin
                  // An unaffordable request consumes the tick; any coin is dropped.
                  if (money_q >= price[buy_idx]) begin
                     money_d     = money_q - price[buy_idx];
                     dispense_d  = buy_hot;
                     drink_sel_d = buy_hot;
                     state_d     = ST_BUY;
                  end
               end else if (coin_5 || coin_10 || coin_50) begin
                  money_d = coin_sat;
               end
            end
         end
         ST_BUY: begin
            if (tick_second) state_d = (money_q != '0) ? ST_RETURN : ST_INSERT;
         end
         ST_RETURN: begin
            if (tick_second) begin
               money_d  = money_ret;
               change_d = 1'b1;
               if (money_ret == '0) state_d = ST_INSERT;
            end
         end
         default: state_d = ST_INSERT;
      endcase
      if (state_d == ST_INSERT && state_q != ST_INSERT) drink_sel_d = 4'b0000;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_INSERT;
         money_q     <= '0;
         dispense_q  <= 4'b0000;
         drink_sel_q <= 4'b0000;
         change_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         money_q     <= money_d;
         dispense_q  <= dispense_d;
         drink_sel_q <= drink_sel_d;
         change_q    <= change_d;
      end
   end

   assign money      = money_q;
   assign state      = state_q;
   assign dispense   = dispense_q;
   assign drink_sel  = drink_sel_q;
   assign change_out = change_q;

endmodule

// File: tb/tb_vending_controller.sv
// Self-checking bench for vending_controller: directed plan scenarios plus a randomized
// run compared against a behavioural credit/phase model.
module tb_vending_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_general, tick_second, coin_5, coin_10, coin_50, cancel;
   logic [3:0] buy_req;
   logic [7:0] money;
   logic [1:0] state;
   logic [3:0] affordable, dispense, drink_sel;
   logic       change_out;

   int vectors    = 0;
   int miscompares = 0;

   // Behavioural model: phase 0 insert, 1 dispensing, 2 returning change.
   int         m_money, m_phase;
   logic [3:0] m_sel, m_disp;
   logic       m_chg;
   int         prices [4] = '{20, 25, 30, 60};

   vending_controller dut (
      .clk          (clk),
      .rst          (rst),
      .tick_general (tick_general),
      .tick_second  (tick_second),
      .coin_5       (coin_5),
      .coin_10      (coin_10),
      .coin_50      (coin_50),
      .cancel       (cancel),
      .buy_req      (buy_req),
      .money        (money),
      .state        (state),
      .affordable   (affordable),
      .dispense     (dispense),
      .drink_sel    (drink_sel),
      .change_out   (change_out)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_money = 0; m_phase = 0; m_sel = 4'b0000; m_disp = 4'b0000; m_chg = 1'b0;
   endtask

   function automatic logic [3:0] model_aff();
      logic [3:0] a;
      a = 4'b0000;
      for (int i = 0; i < 4; i++) a[i] = (m_phase == 0) && (m_money >= prices[i]);
      return a;
   endfunction

   task automatic model_step(input logic tg, ts, c5, c10, c50, can, input logic [3:0] b);
      int k, d;
      m_disp = 4'b0000;
      m_chg  = 1'b0;
      if (m_phase == 0) begin
         if (tg) begin
            if (can) begin
               if (m_money > 0) m_phase = 2;
            end else if (b != 4'b0000) begin
               k = 0;
               while (!b[k]) k++;
               if (m_money >= prices[k]) begin
                  m_money -= prices[k];
                  m_disp  = 4'b0001 << k;
                  m_sel   = 4'b0001 << k;
                  m_phase = 1;
               end
            end else if (c5 || c10 || c50) begin
               m_money += c5 ? 5 : (c10 ? 10 : 50);
               if (m_money > 99) m_money = 99;
            end
         end
      end else if (m_phase == 1) begin
         if (ts) begin
            m_phase = (m_money > 0) ? 2 : 0;
            if (m_phase == 0) m_sel = 4'b0000;
         end
      end else begin
         if (ts) begin
            d = (m_money < 5) ? m_money : 5;
            m_money -= d;
            m_chg = 1'b1;
            if (m_money == 0) begin
               m_phase = 0;
               m_sel   = 4'b0000;
            end
         end
      end
   endtask

   // Applies one clock of stimulus, advances the model, leaves time at posedge+1.
   task automatic cycle(input logic tg, ts, c5, c10, c50, can, input logic [3:0] b);
      tick_general = tg; tick_second = ts; coin_5 = c5; coin_10 = c10; coin_50 = c50;
      cancel = can; buy_req = b;
      @(posedge clk);
      model_step(tg, ts, c5, c10, c50, can, b);
      #1;
      tick_general = 0; tick_second = 0; coin_5 = 0; coin_10 = 0; coin_50 = 0;
      cancel = 0; buy_req = 4'b0000;
   endtask

   task automatic coin(input int v);
      cycle(1, 0, v == 5, v == 10, v == 50, 0, 4'b0000);
   endtask

   task automatic tsec();
      cycle(0, 1, 0, 0, 0, 0, 4'b0000);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick_general = 0; tick_second = 0; coin_5 = 0; coin_10 = 0; coin_50 = 0;
      cancel = 0; buy_req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({state, money} !== {2'b00, 8'd0}) begin
         miscompares++;
         $display("FAIL reset_state_money: got %b/%0d want 00/0", state, money);
      end
      vectors++;
      if ({dispense, drink_sel, change_out, affordable} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got disp=%b sel=%b chg=%b aff=%b want all 0",
                  dispense, drink_sel, change_out, affordable);
      end
      model_reset();
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_coin_buy();
      coin(10); coin(10);
      cycle(0, 0, 0, 0, 1, 0, 4'b0000);  // coin without tick_general is ignored
      coin(5);
      vectors++;
      if ({state, money, affordable} !== {2'b00, 8'd25, 4'b0011}) begin
         miscompares++;
         $display("FAIL coins_25: got st=%b m=%0d aff=%b want 00/25/0011", state, money,
                  affordable);
      end
      cycle(1, 0, 0, 0, 0, 0, 4'b0010);
      vectors++;
      if ({dispense, money, state, drink_sel} !== {4'b0010, 8'd0, 2'b01, 4'b0010}) begin
         miscompares++;
         $display("FAIL buy_s: got disp=%b m=%0d st=%b sel=%b want 0010/0/01/0010",
                  dispense, money, state, drink_sel);
      end
      cycle(0, 0, 0, 0, 0, 0, 4'b0000);
      vectors++;
      if ({dispense, state} !== {4'b0000, 2'b01}) begin
         miscompares++;
         $display("FAIL buy_s_pulse: got disp=%b st=%b want 0000/01", dispense, state);
      end
      tsec();
      vectors++;
      if ({state, drink_sel, change_out} !== {2'b00, 4'b0000, 1'b0}) begin
         miscompares++;
         $display("FAIL buy_s_done: got st=%b sel=%b chg=%b want 00/0000/0", state,
                  drink_sel, change_out);
      end
   endtask

   task automatic test_saturate_return();
      int pulses = 0;
      coin(50); coin(10); coin(10); coin(10); coin(10); coin(5);
      coin(50);
      vectors++;
      if (money !== 8'd99) begin
         miscompares++;
         $display("FAIL saturate: got m=%0d want 99", money);
      end
      cycle(1, 0, 0, 0, 0, 0, 4'b1000);
      vectors++;
      if ({money, state, dispense} !== {8'd39, 2'b01, 4'b1000}) begin
         miscompares++;
         $display("FAIL buy_f: got m=%0d st=%b disp=%b want 39/01/1000", money, state,
                  dispense);
      end
      tsec();
      vectors++;
      if ({state, change_out, money} !== {2'b10, 1'b0, 8'd39}) begin
         miscompares++;
         $display("FAIL enter_return: got st=%b chg=%b m=%0d want 10/0/39", state,
                  change_out, money);
      end
      for (int k = 1; k <= 8; k++) begin
         tsec();
         pulses += int'(change_out);
         vectors++;
         if (money !== 8'((k == 8) ? 0 : 39 - 5 * k)) begin
            miscompares++;
            $display("FAIL return_step%0d: got m=%0d want %0d", k, money,
                     (k == 8) ? 0 : 39 - 5 * k);
         end
         cycle(0, 0, 0, 0, 0, 0, 4'b0000);
         pulses += int'(change_out);
      end
      vectors++;
      if ({state, 32'(pulses)} !== {2'b00, 32'd8}) begin
         miscompares++;
         $display("FAIL return_done: got st=%b pulses=%0d want 00/8", state, pulses);
      end
   endtask

   task automatic test_insufficient();
      coin(10); coin(5);
      cycle(1, 0, 1, 0, 0, 0, 4'b0001);
      vectors++;
      if ({money, state, dispense} !== {8'd15, 2'b00, 4'b0000}) begin
         miscompares++;
         $display("FAIL insufficient: got m=%0d st=%b disp=%b want 15/00/0000", money,
                  state, dispense);
      end
   endtask

   task automatic test_cancel_priority();
      int pulses = 0;
      coin(10); coin(10); coin(5);
      cycle(1, 0, 0, 1, 0, 1, 4'b0001);
      vectors++;
      if ({state, money, dispense, affordable} !== {2'b10, 8'd40, 4'b0000, 4'b0000}) begin
         miscompares++;
         $display("FAIL cancel_prio: got st=%b m=%0d disp=%b aff=%b want 10/40/0000/0000",
                  state, money, dispense, affordable);
      end
      coin(50);
      vectors++;
      if (money !== 8'd40) begin
         miscompares++;
         $display("FAIL coin_in_return: got m=%0d want 40", money);
      end
      repeat (8) begin
         tsec();
         pulses += int'(change_out);
      end
      vectors++;
      if ({state, money, 32'(pulses)} !== {2'b00, 8'd0, 32'd8}) begin
         miscompares++;
         $display("FAIL cancel_refund: got st=%b m=%0d pulses=%0d want 00/0/8", state,
                  money, pulses);
      end
   endtask

   task automatic test_reset_midreturn();
      coin(50);
      cycle(1, 0, 0, 0, 0, 1, 4'b0000);
      vectors++;
      if ({state, money} !== {2'b10, 8'd50}) begin
         miscompares++;
         $display("FAIL pre_abort: got st=%b m=%0d want 10/50", state, money);
      end
      #3 rst = 1'b0;
      #1;
      vectors++;
      if ({state, money, change_out} !== {2'b00, 8'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL async_abort: got st=%b m=%0d chg=%b want 00/0/0", state, money,
                  change_out);
      end
      model_reset();
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic test_random();
      logic tg, ts, c5, c10, c50, can;
      logic [3:0] b;
      for (int n = 0; n < 800; n++) begin
         tg  = ($urandom_range(1) == 1);
         ts  = ($urandom_range(5) == 0);
         c5  = ($urandom_range(3) == 0);
         c10 = ($urandom_range(3) == 0);
         c50 = ($urandom_range(4) == 0);
         can = ($urandom_range(19) == 0);
         b   = ($urandom_range(4) == 0) ? 4'($urandom) : 4'b0000;
         cycle(tg, ts, c5, c10, c50, can, b);
         vectors++;
         if ({money, state} !== {8'(m_money), 2'(m_phase)}) begin
            miscompares++;
            $display("FAIL rand_money_state@%0d: got m=%0d st=%b want m=%0d st=%0d", n,
                     money, state, m_money, m_phase);
         end
         vectors++;
         if ({dispense, drink_sel, change_out} !== {m_disp, m_sel, m_chg}) begin
            miscompares++;
            $display("FAIL rand_pulses@%0d: got disp=%b sel=%b chg=%b want %b/%b/%b", n,
                     dispense, drink_sel, change_out, m_disp, m_sel, m_chg);
         end
         vectors++;
         if (affordable !== model_aff()) begin
            miscompares++;
            $display("FAIL rand_afford@%0d: got %b want %b", n, affordable, model_aff());
         end
         vectors++;
         if ((dispense != 4'b0000) && change_out) begin
            miscompares++;
            $display("FAIL rand_exclusive@%0d: got disp=%b chg=1 want not both", n, dispense);
         end
      end
   endtask

   initial begin
      test_reset();
      test_coin_buy();
      test_saturate_return();
      test_insufficient();
      test_cancel_priority();
      test_reset_midreturn();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
